// File: rtl/button_debounce_if.sv
// Button conditioner signal bundle: raw pin in, clean level and event strobes out.
// The release strobe is carried as release_evt because "release" is a reserved word.
interface button_debounce_if;
   logic btn_raw;
   logic level;
   logic press;
   logic release_evt;
   logic long_press;
   logic repeat_pulse;

   modport slave (
      input  btn_raw,
      output level, press, release_evt, long_press, repeat_pulse
   );

   modport master (
      output btn_raw,
      input  level, press, release_evt, long_press, repeat_pulse
   );
endinterface

// File: rtl/button_debounce.sv
// Synchronise, debounce and decode the push-button into level/press/release/long-press.
// Define BUTTON_DEBOUNCE_REPEAT_EN to add an auto-repeat strobe after long_press.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 480000,
   parameter int unsigned LONG_CYCLES     = 48000000,
   parameter int unsigned REPEAT_CYCLES   = 12000000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   button_debounce_if.slave bif
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] D_ONE  = DW'(1);
   localparam logic [HW-1:0] L_FIRE = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] L_SAT  = HW'(LONG_CYCLES);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   state_t        state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic          sync1, sync2, p;
   logic          press_q, press_n;
   logic          rel_q, rel_n;
   logic          long_q, long_n;
   logic          holding;

   // Synchroniser idles at the released pin value so reset exit is quiet.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= ACTIVE_LOW;
         sync2 <= ACTIVE_LOW;
      end else begin
         sync1 <= bif.btn_raw;
         sync2 <= sync1;
      end
   end

   assign p       = sync2 ^ ACTIVE_LOW;
   assign holding = (state == HELD) || (state == RELEASE_WAIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         dcnt    <= '0;
         hcnt    <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         state   <= state_n;
         dcnt    <= dcnt_n;
         hcnt    <= hcnt_n;
         press_q <= press_n;
         rel_q   <= rel_n;
         long_q  <= long_n;
      end
   end

   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      press_n = 1'b0;
      rel_n   = 1'b0;
      long_n  = 1'b0;

      // Hold time keeps running through release bounce; it saturates so long_press fires once.
      if (holding) begin
         if (hcnt == L_FIRE) long_n = 1'b1;
         if (hcnt != L_SAT)  hcnt_n = hcnt + 1'b1;
      end

      unique case (state)
         IDLE: begin
            if (p) begin
               state_n = PRESS_WAIT;
               dcnt_n  = D_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!p) begin
               state_n = IDLE;
               dcnt_n  = '0;
            end else if (dcnt == D_LAST) begin
               state_n = HELD;
               press_n = 1'b1;
               dcnt_n  = '0;
               hcnt_n  = '0;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         HELD: begin
            if (!p) begin
               state_n = RELEASE_WAIT;
               dcnt_n  = D_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (p) begin
               state_n = HELD;
               dcnt_n  = '0;
            end else if (dcnt == D_LAST) begin
               state_n = IDLE;
               rel_n   = 1'b1;
               dcnt_n  = '0;
               hcnt_n  = '0;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            dcnt_n  = '0;
            hcnt_n  = '0;
         end
      endcase
   end

   assign bif.level       = holding;
   assign bif.press       = press_q;
   assign bif.release_evt = rel_q;
   assign bif.long_press  = long_q;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rcnt, rcnt_n;
   logic          rep_q, rep_n;

   // A saturated hold counter means long_press has already fired in this hold.
   always_comb begin
      rcnt_n = rcnt;
      rep_n  = 1'b0;
      if (state_n == IDLE) begin
         rcnt_n = '0;
      end else if (holding && (hcnt == L_SAT)) begin
         if (rcnt == R_LAST) begin
            rcnt_n = '0;
            rep_n  = 1'b1;
         end else begin
            rcnt_n = rcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rcnt  <= '0;
         rep_q <= 1'b0;
      end else begin
         rcnt  <= rcnt_n;
         rep_q <= rep_n;
      end
   end

   assign bif.repeat_pulse = rep_q;
`else
   // Kept so the parameter list is identical in both builds.
   localparam int unsigned unused_repeat_cycles = REPEAT_CYCLES;
   assign bif.repeat_pulse = 1'b0;
`endif

endmodule
